// File: rtl/fetch_if.sv
// Fetch-unit bus: instruction-cache request/response plus the decode-side valid/ready channel.
// The master modport is the fetch unit; the slave modport is the cache/decode environment.
interface fetch_if;
   logic [63:0] ic_addr;
   logic        ic_read_en;
   logic [31:0] ic_data;
   logic        ic_stall;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic        inst_ready;

   modport master (
      output ic_addr, ic_read_en, inst_valid, inst, inst_pc,
      input  ic_data, ic_stall, redirect_valid, redirect_pc, inst_ready
   );

   modport slave (
      input  ic_addr, ic_read_en, inst_valid, inst, inst_pc,
      output ic_data, ic_stall, redirect_valid, redirect_pc, inst_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC register, cache request, and a small {pc, inst} queue toward decode.
// A redirect flushes the queue and reloads the PC; the flush takes priority over any pop that cycle.
module fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int          DEPTH    = 2
) (
   input  logic     clk,
   input  logic     rst_n,
   fetch_if.master  bus
);
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = $clog2(DEPTH) + 1;
   localparam bit IS_POW2 = (DEPTH & (DEPTH - 1)) == 0;

   logic [63:0]      r_pc;
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;
   logic [63:0]      r_pc_mem   [DEPTH];
   logic [31:0]      r_inst_mem [DEPTH];

   logic w_read_en;
   logic w_push;
   logic w_pop;
   logic w_unused_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (IS_POW2)
         return p + PTR_W'(1);
      else
         return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Registered count only, so decode's ready never reaches the cache request path.
   assign w_read_en   = rst_n && !bus.redirect_valid && (r_count < CNT_W'(DEPTH));
   assign w_push      = w_read_en && !bus.ic_stall;
   assign w_pop       = (r_count != '0) && bus.inst_ready && !bus.redirect_valid;
   assign w_unused_ok = &{1'b0, bus.redirect_pc[1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc    <= RESET_PC;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_pc_mem[i]   <= '0;
            r_inst_mem[i] <= '0;
         end
      end else if (bus.redirect_valid) begin
         r_pc    <= {bus.redirect_pc[63:2], 2'b00};
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_pc_mem[r_tail]   <= r_pc;
            r_inst_mem[r_tail] <= bus.ic_data;
            r_tail             <= ptr_inc(r_tail);
            r_pc               <= r_pc + 64'd4;
         end
         if (w_pop)
            r_head <= ptr_inc(r_head);
         if (w_push && !w_pop)
            r_count <= r_count + CNT_W'(1);
         else if (w_pop && !w_push)
            r_count <= r_count - CNT_W'(1);
      end
   end

   assign bus.ic_addr    = r_pc;
   assign bus.ic_read_en = w_read_en;
   assign bus.inst_valid = (r_count != '0);
   assign bus.inst       = r_inst_mem[r_head];
   assign bus.inst_pc    = r_pc_mem[r_head];
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_fetch_unit;
   localparam logic [63:0] RESET_PC = 64'h1000;
   localparam int          DEPTH    = 2;

   logic clk;
   logic rst_n;
   fetch_if bus_if ();

   fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] data_of(input logic [63:0] pc);
      return {pc[31:8] ^ 24'h5A5A5A, 8'hA0 + pc[7:0]};
   endfunction

   assign bus_if.ic_data = data_of(bus_if.ic_addr);

   int n_checks = 0;
   int n_pass   = 0;

   logic [63:0] m_pc;
   logic [63:0] m_q [$];
   logic [63:0] delivered [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic drive(input logic rv, input logic [63:0] rpc, input logic st, input logic rd);
      bus_if.redirect_valid = rv;
      bus_if.redirect_pc    = rpc;
      bus_if.ic_stall       = st;
      bus_if.inst_ready     = rd;
   endtask

   // One clock cycle against the reference model; called at posedge+1, returns at next posedge+1.
   task automatic cycle(input logic rv, input logic [63:0] rpc, input logic st, input logic rd);
      logic e_ren;
      drive(rv, rpc, st, rd);
      @(negedge clk);
      e_ren = !rv && (m_q.size() < DEPTH);
      chk("ic_read_en", {63'b0, bus_if.ic_read_en}, {63'b0, e_ren});
      chk("ic_addr", bus_if.ic_addr, m_pc);
      chk("inst_valid", {63'b0, bus_if.inst_valid}, {63'b0, m_q.size() > 0});
      if (m_q.size() > 0) begin
         chk("inst_pc", bus_if.inst_pc, m_q[0]);
         chk("inst", {32'b0, bus_if.inst}, {32'b0, data_of(m_q[0])});
      end
      if (bus_if.inst_valid && rd && !rv)
         delivered.push_back(bus_if.inst_pc);
      @(posedge clk);
      if (rv) begin
         m_q.delete();
         m_pc = rpc & ~64'h3;
      end else begin
         if (m_q.size() > 0 && rd)
            void'(m_q.pop_front());
         if (e_ren && !st) begin
            m_q.push_back(m_pc);
            m_pc = m_pc + 64'd4;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_read_en", {63'b0, bus_if.ic_read_en}, 64'h0);
      chk("rst_valid", {63'b0, bus_if.inst_valid}, 64'h0);
      chk("rst_addr", bus_if.ic_addr, RESET_PC);
      chk("rst_xfree", {63'b0, $isunknown({bus_if.inst, bus_if.inst_pc})}, 64'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_q.delete();
      m_pc = RESET_PC;
   endtask

   typedef struct {
      logic        rd;
      logic        e_ren;
      logic [63:0] e_addr;
      logic        e_valid;
      logic [63:0] e_pc;
   } vec_t;

   vec_t tbl [8];
   logic [63:0] wrap_exp [4];
   int n1004;

   initial begin
      // Decode back-pressured from reset: two pushes, hold at 1008, then drain and resume.
      tbl[0] = '{1'b0, 1'b1, 64'h1000, 1'b0, 64'h0};
      tbl[1] = '{1'b0, 1'b1, 64'h1004, 1'b1, 64'h1000};
      tbl[2] = '{1'b0, 1'b0, 64'h1008, 1'b1, 64'h1000};
      tbl[3] = '{1'b0, 1'b0, 64'h1008, 1'b1, 64'h1000};
      tbl[4] = '{1'b1, 1'b0, 64'h1008, 1'b1, 64'h1000};
      tbl[5] = '{1'b1, 1'b1, 64'h1008, 1'b1, 64'h1004};
      tbl[6] = '{1'b1, 1'b1, 64'h100C, 1'b1, 64'h1008};
      tbl[7] = '{1'b1, 1'b1, 64'h1010, 1'b1, 64'h100C};
      wrap_exp[0] = 64'hFFFF_FFFF_FFFF_FFF8;
      wrap_exp[1] = 64'hFFFF_FFFF_FFFF_FFFC;
      wrap_exp[2] = 64'h0;
      wrap_exp[3] = 64'h4;

      rst_n = 1'b1;
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      do_reset();

      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 64'h0, 1'b0, tbl[i].rd);
         @(negedge clk);
         chk($sformatf("vec%0d_read_en", i), {63'b0, bus_if.ic_read_en}, {63'b0, tbl[i].e_ren});
         chk($sformatf("vec%0d_addr", i), bus_if.ic_addr, tbl[i].e_addr);
         chk($sformatf("vec%0d_valid", i), {63'b0, bus_if.inst_valid}, {63'b0, tbl[i].e_valid});
         if (tbl[i].e_valid) begin
            chk($sformatf("vec%0d_pc", i), bus_if.inst_pc, tbl[i].e_pc);
            chk($sformatf("vec%0d_inst", i), {32'b0, bus_if.inst}, {32'b0, data_of(tbl[i].e_pc)});
         end
         @(posedge clk);
         #1;
      end

      // Streaming from reset, then a 3-cycle stall at 1004.
      do_reset();
      delivered.delete();
      cycle(1'b0, 64'h0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 64'h0, 1'b1, 1'b1);
      chk("stall_addr_hold", bus_if.ic_addr, 64'h1004);
      for (int i = 0; i < 5; i++) cycle(1'b0, 64'h0, 1'b0, 1'b1);
      n1004 = 0;
      foreach (delivered[i]) if (delivered[i] == 64'h1004) n1004++;
      chk("stall_once", 64'(n1004), 64'd1);
      chk("stall_first", delivered[0], 64'h1000);

      // Redirect with a full queue and an active stall.
      do_reset();
      cycle(1'b0, 64'h0, 1'b0, 1'b0);
      cycle(1'b0, 64'h0, 1'b0, 1'b0);
      cycle(1'b1, 64'h2003, 1'b1, 1'b1);
      chk("redir_valid", {63'b0, bus_if.inst_valid}, 64'h0);
      chk("redir_addr", bus_if.ic_addr, 64'h2000);
      delivered.delete();
      for (int i = 0; i < 4; i++) cycle(1'b0, 64'h0, 1'b0, 1'b1);
      chk("redir_first", delivered[0], 64'h2000);

      // Back-to-back redirects, the last wins, landing near the top of the address space.
      cycle(1'b1, 64'h3000, 1'b0, 1'b1);
      cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b1);
      delivered.delete();
      for (int i = 0; i < 7; i++) cycle(1'b0, 64'h0, 1'b0, 1'b1);
      chk("wrap_count", {63'b0, delivered.size() >= 4}, 64'h1);
      for (int i = 0; i < 4; i++)
         chk($sformatf("wrap_pc%0d", i), delivered[i], wrap_exp[i]);

      // Asynchronous reset mid-cycle with a full queue and a stall.
      cycle(1'b0, 64'h0, 1'b0, 1'b0);
      cycle(1'b0, 64'h0, 1'b0, 1'b0);
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_read_en", {63'b0, bus_if.ic_read_en}, 64'h0);
      chk("async_valid", {63'b0, bus_if.inst_valid}, 64'h0);
      chk("async_addr", bus_if.ic_addr, RESET_PC);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_q.delete();
      m_pc = RESET_PC;
      delivered.delete();
      for (int i = 0; i < 3; i++) cycle(1'b0, 64'h0, 1'b0, 1'b1);
      chk("async_restart", delivered[0], RESET_PC);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         logic rv, st, rd;
         logic [63:0] rpc;
         rv  = ($urandom_range(0, 19) == 0);
         st  = ($urandom_range(0, 9) < 3);
         rd  = ($urandom_range(0, 9) < 6);
         rpc = {$urandom(), $urandom()};
         cycle(rv, rpc, st, rd);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
